// File: rtl/fpu_issue_ctrl_if.sv
// Bundles the execute-stage request, FPU drive, response and fflags CSR signals
// of the FPU issue controller; the controller uses the slave view.
interface fpu_issue_ctrl_if;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [2:0]  req_rm;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_rs2_lsb;
    logic [4:0]  req_rd;
    logic [2:0]  csr_frm;

    logic        fpu_start;
    logic [4:0]  fpu_op;
    logic [2:0]  fpu_rounding_mode;
    logic [2:0]  fpu_dyn_rm;
    logic [31:0] fpu_A;
    logic [31:0] fpu_B;
    logic        fpu_rs2_lsb;
    logic [31:0] fpu_out;
    logic        fpu_done;
    logic        fpu_nv;
    logic        fpu_dz;
    logic        fpu_of;
    logic        fpu_uf;
    logic        fpu_nx;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [4:0]  rsp_fflags;
    logic        rsp_illegal;
    logic        rsp_timeout;

    logic        csr_fflags_we;
    logic [4:0]  csr_fflags_wdata;
    logic [4:0]  fflags_acc;

    modport slave (
        input  flush, req_valid, req_op, req_rm, req_a, req_b, req_rs2_lsb, req_rd, csr_frm,
        input  fpu_out, fpu_done, fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx,
        input  rsp_ready, csr_fflags_we, csr_fflags_wdata,
        output req_ready, fpu_start, fpu_op, fpu_rounding_mode, fpu_dyn_rm, fpu_A, fpu_B, fpu_rs2_lsb,
        output rsp_valid, rsp_data, rsp_rd, rsp_fflags, rsp_illegal, rsp_timeout, fflags_acc
    );

    modport master (
        output flush, req_valid, req_op, req_rm, req_a, req_b, req_rs2_lsb, req_rd, csr_frm,
        output fpu_out, fpu_done, fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx,
        output rsp_ready, csr_fflags_we, csr_fflags_wdata,
        input  req_ready, fpu_start, fpu_op, fpu_rounding_mode, fpu_dyn_rm, fpu_A, fpu_B, fpu_rs2_lsb,
        input  rsp_valid, rsp_data, rsp_rd, rsp_fflags, rsp_illegal, rsp_timeout, fflags_acc
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issues one FP instruction at a time to the FPU, returns its result/flags,
// accumulates fflags and aborts operations that never complete.
module fpu_issue_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic           clk,
    input  logic           reset,
    fpu_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              start_q, start_d;
    logic [4:0]        op_q, op_d;
    logic [2:0]        rm_q, rm_d;
    logic [2:0]        dyn_rm_q, dyn_rm_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [4:0]        rsp_fflags_q, rsp_fflags_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic [4:0]        acc_q, acc_d;

    logic              capture;
    logic              rm_sensitive;
    logic [2:0]        eff_rm;
    logic [4:0]        flags_in;

    assign eff_rm       = (bus.req_rm == 3'b111) ? bus.csr_frm : bus.req_rm;
    assign rm_sensitive = bus.req_op inside {5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                             5'b01011, 5'b11000, 5'b11010};
    assign flags_in     = {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            start_q      <= 1'b0;
            op_q         <= '0;
            rm_q         <= '0;
            dyn_rm_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rs2_q        <= 1'b0;
            rd_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_fflags_q <= '0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            op_q         <= op_d;
            rm_q         <= rm_d;
            dyn_rm_q     <= dyn_rm_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_fflags_q <= rsp_fflags_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
            acc_q        <= acc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_d      = start_q;
        op_d         = op_q;
        rm_d         = rm_q;
        dyn_rm_d     = dyn_rm_q;
        a_d          = a_q;
        b_d          = b_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_fflags_d = rsp_fflags_q;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        capture      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d     = bus.req_op;
                    rm_d     = bus.req_rm;
                    dyn_rm_d = bus.csr_frm;
                    a_d      = bus.req_a;
                    b_d      = bus.req_b;
                    rs2_d    = bus.req_rs2_lsb;
                    rd_d     = bus.req_rd;
                    // Reserved rounding modes are answered directly without touching the FPU
                    if (rm_sensitive && (eff_rm >= 3'b101)) begin
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = '0;
                        rsp_fflags_d = '0;
                        illegal_d    = 1'b1;
                    end else begin
                        state_d = BUSY;
                        start_d = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                if (bus.fpu_done) begin
                    capture      = 1'b1;
                    start_d      = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = bus.fpu_out;
                    rsp_fflags_d = flags_in;
                    state_d      = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    start_d      = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = '0;
                    rsp_fflags_d = '0;
                    timeout_d    = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    illegal_d   = 1'b0;
                    timeout_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides done, timeout and response acceptance
        if (bus.flush) begin
            state_d      = IDLE;
            cnt_d        = '0;
            start_d      = 1'b0;
            rsp_valid_d  = 1'b0;
            rsp_data_d   = '0;
            rsp_fflags_d = '0;
            illegal_d    = 1'b0;
            timeout_d    = 1'b0;
            capture      = 1'b0;
        end

        acc_d = acc_q;
        if (capture) begin
            acc_d = (bus.csr_fflags_we ? bus.csr_fflags_wdata : acc_q) | flags_in;
        end else if (bus.csr_fflags_we) begin
            acc_d = bus.csr_fflags_wdata;
        end
    end

    assign bus.req_ready         = (state_q == IDLE);
    assign bus.fpu_start         = start_q;
    assign bus.fpu_op            = op_q;
    assign bus.fpu_rounding_mode = rm_q;
    assign bus.fpu_dyn_rm        = dyn_rm_q;
    assign bus.fpu_A             = a_q;
    assign bus.fpu_B             = b_q;
    assign bus.fpu_rs2_lsb       = rs2_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_data          = rsp_data_q;
    assign bus.rsp_rd            = rd_q;
    assign bus.rsp_fflags        = rsp_fflags_q;
    assign bus.rsp_illegal       = illegal_q;
    assign bus.rsp_timeout       = timeout_q;
    assign bus.fflags_acc        = acc_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: a behavioural FPU model with
// configurable latency plus a transaction-level reference for responses and fflags.
module tb_fpu_issue_ctrl;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpu_issue_ctrl_if bus();

    fpu_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // FPU model: done rises combinationally once start has been high for model_lat+1 cycles
    int          model_lat = 0;
    bit          model_hang = 0;
    logic [4:0]  model_flags = '0;
    bit          model_fixed_en = 0;
    logic [31:0] model_fixed = '0;
    int          busy_cnt;

    function automatic logic [31:0] scramble(logic [31:0] a, logic [31:0] b, logic [4:0] op,
                                             logic [2:0] rm, logic [2:0] frm, logic rs2);
        return a ^ {b[15:0], b[31:16]} ^ {op, rm, frm, rs2, 20'h5A5A5};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) busy_cnt <= 0;
        else if (bus.fpu_start) busy_cnt <= busy_cnt + 1;
        else busy_cnt <= 0;
    end

    assign bus.fpu_done = bus.fpu_start && !model_hang && (busy_cnt == model_lat);
    assign bus.fpu_out  = model_fixed_en ? model_fixed :
                          scramble(bus.fpu_A, bus.fpu_B, bus.fpu_op, bus.fpu_rounding_mode,
                                   bus.fpu_dyn_rm, bus.fpu_rs2_lsb);
    assign {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx} =
           bus.fpu_done ? model_flags : ~model_flags;

    logic [4:0]  ref_acc;

    int          obs_start, obs_wait;
    logic [31:0] obs_data;
    logic [4:0]  obs_ff, obs_rd, obs_acc;
    logic        obs_ill, obs_to, obs_after_valid, obs_after_ready;
    bit          obs_latch_ok, obs_stable, obs_got_rsp;

    function automatic bit is_illegal(logic [4:0] op, logic [2:0] rm, logic [2:0] frm);
        logic [2:0] eff;
        bit sens;
        eff  = (rm == 3'd7) ? frm : rm;
        sens = (op == 5'd0) || (op == 5'd1) || (op == 5'd2) || (op == 5'd3) ||
               (op == 5'd11) || (op == 5'd24) || (op == 5'd26);
        return sens && (eff >= 3'd5);
    endfunction

    // Drives one request, observes the FPU side and the response, then retires it
    task automatic do_txn(input logic [4:0] op, input logic [2:0] rm, input logic [2:0] frm,
                          input logic [31:0] a, input logic [31:0] b, input logic rs2,
                          input logic [4:0] rd, input bit wr_cap, input logic [4:0] wdata,
                          input int hold);
        @(negedge clk);
        bus.req_op = op; bus.req_rm = rm; bus.csr_frm = frm;
        bus.req_a = a; bus.req_b = b; bus.req_rs2_lsb = rs2; bus.req_rd = rd;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a = $urandom; bus.req_b = $urandom; bus.csr_frm = 3'($urandom);
        obs_start = 0; obs_wait = 1; obs_latch_ok = 1; obs_got_rsp = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.rsp_valid) begin
                obs_got_rsp = 1;
                break;
            end
            if (bus.fpu_start) begin
                obs_start++;
                if (bus.fpu_op !== op || bus.fpu_rounding_mode !== rm || bus.fpu_dyn_rm !== frm ||
                    bus.fpu_A !== a || bus.fpu_B !== b || bus.fpu_rs2_lsb !== rs2)
                    obs_latch_ok = 0;
            end
            if (bus.fpu_done && wr_cap) begin
                bus.csr_fflags_we = 1'b1;
                bus.csr_fflags_wdata = wdata;
            end
            @(negedge clk);
            bus.csr_fflags_we = 1'b0;
            obs_wait++;
        end
        obs_data = bus.rsp_data; obs_ff = bus.rsp_fflags; obs_rd = bus.rsp_rd;
        obs_ill = bus.rsp_illegal; obs_to = bus.rsp_timeout; obs_acc = bus.fflags_acc;
        obs_stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== obs_data || bus.rsp_fflags !== obs_ff ||
                bus.req_ready !== 1'b0)
                obs_stable = 0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        obs_after_valid = bus.rsp_valid;
        obs_after_ready = bus.req_ready;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.flush = 0; bus.req_valid = 0; bus.req_op = '0; bus.req_rm = '0; bus.req_a = '0;
        bus.req_b = '0; bus.req_rs2_lsb = 0; bus.req_rd = '0; bus.csr_frm = '0;
        bus.rsp_ready = 0; bus.csr_fflags_we = 0; bus.csr_fflags_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ref_acc = '0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.fpu_start !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_hs got ready=%b start=%b valid=%b exp 1/0/0",
                     bus.req_ready, bus.fpu_start, bus.rsp_valid);
        end
        checks++;
        if (bus.rsp_data !== 32'h0 || bus.fflags_acc !== 5'h0 || bus.rsp_illegal !== 1'b0 ||
            bus.rsp_timeout !== 1'b0 || bus.fpu_A !== 32'h0 || bus.fpu_op !== 5'h0 || bus.rsp_rd !== 5'h0) begin
            failures++;
            $display("[TB] FAIL reset_fields got data=%h acc=%b ill=%b to=%b A=%h op=%h rd=%h exp all 0",
                     bus.rsp_data, bus.fflags_acc, bus.rsp_illegal, bus.rsp_timeout, bus.fpu_A,
                     bus.fpu_op, bus.rsp_rd);
        end
    endtask

    task automatic test_csr_write;
        @(negedge clk);
        bus.csr_fflags_we = 1'b1; bus.csr_fflags_wdata = 5'b10110;
        @(negedge clk);
        bus.csr_fflags_we = 1'b0;
        checks++;
        if (bus.fflags_acc !== 5'b10110) begin
            failures++;
            $display("[TB] FAIL csr_write got=%b exp=%b", bus.fflags_acc, 5'b10110);
        end
        bus.csr_fflags_we = 1'b1; bus.csr_fflags_wdata = 5'b00000;
        @(negedge clk);
        bus.csr_fflags_we = 1'b0;
        ref_acc = '0;
    endtask

    task automatic test_single_cycle;
        model_lat = 0; model_hang = 0; model_flags = 5'b00000;
        model_fixed_en = 1; model_fixed = 32'h40400000;
        do_txn(5'b00000, 3'b000, 3'b000, 32'h3F800000, 32'h40000000, 1'b0, 5'd7, 0, 5'd0, 0);
        checks++;
        if (obs_data !== 32'h40400000 || obs_ff !== 5'b0 || obs_rd !== 5'd7) begin
            failures++;
            $display("[TB] FAIL fadd_result got data=%h ff=%b rd=%0d exp 40400000/00000/7", obs_data, obs_ff, obs_rd);
        end
        checks++;
        if (obs_start !== 1 || obs_wait !== 2) begin
            failures++;
            $display("[TB] FAIL fadd_latency got start=%0d wait=%0d exp 1/2", obs_start, obs_wait);
        end
        checks++;
        if (obs_acc !== 5'b0 || !obs_latch_ok || obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fadd_retire got acc=%b latch=%0d valid=%b ready=%b exp 00000/1/0/1",
                     obs_acc, obs_latch_ok, obs_after_valid, obs_after_ready);
        end
    endtask

    task automatic test_multi_cycle;
        model_lat = 19; model_hang = 0; model_flags = 5'b01000;
        model_fixed_en = 1; model_fixed = 32'h7F800000;
        do_txn(5'b00011, 3'b000, 3'b000, 32'h3F800000, 32'h00000000, 1'b0, 5'd12, 0, 5'd0, 0);
        ref_acc = 5'b01000;
        checks++;
        if (obs_start !== 20 || obs_wait !== 21) begin
            failures++;
            $display("[TB] FAIL fdiv_latency got start=%0d wait=%0d exp 20/21", obs_start, obs_wait);
        end
        checks++;
        if (obs_data !== 32'h7F800000 || obs_ff !== 5'b01000 || obs_acc !== ref_acc) begin
            failures++;
            $display("[TB] FAIL fdiv_result got data=%h ff=%b acc=%b exp 7f800000/01000/%b",
                     obs_data, obs_ff, obs_acc, ref_acc);
        end
    endtask

    task automatic test_illegal;
        model_lat = 0; model_hang = 0; model_flags = 5'b11111; model_fixed_en = 0;
        do_txn(5'b00010, 3'b111, 3'b101, $urandom, $urandom, 1'b0, 5'd3, 0, 5'd0, 0);
        checks++;
        if (obs_ill !== 1'b1 || obs_start !== 0 || obs_wait !== 1 || obs_data !== 32'h0 ||
            obs_ff !== 5'b0 || obs_acc !== ref_acc || obs_to !== 1'b0) begin
            failures++;
            $display("[TB] FAIL illegal_dyn got ill=%b start=%0d wait=%0d data=%h ff=%b acc=%b exp 1/0/1/0/0/%b",
                     obs_ill, obs_start, obs_wait, obs_data, obs_ff, obs_acc, ref_acc);
        end
        checks++;
        if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL illegal_retire got valid=%b ready=%b exp 0/1", obs_after_valid, obs_after_ready);
        end
        do_txn(5'b11000, 3'b110, 3'b000, $urandom, $urandom, 1'b1, 5'd4, 0, 5'd0, 0);
        checks++;
        if (obs_ill !== 1'b1 || obs_start !== 0) begin
            failures++;
            $display("[TB] FAIL illegal_static got ill=%b start=%0d exp 1/0", obs_ill, obs_start);
        end
    endtask

    task automatic test_rm_boundaries;
        logic [31:0] a, b;
        model_lat = 1; model_hang = 0; model_flags = 5'b00000; model_fixed_en = 0;
        a = $urandom; b = $urandom;
        do_txn(5'b00100, 3'b111, 3'b111, a, b, 1'b1, 5'd9, 0, 5'd0, 0);
        checks++;
        if (obs_ill !== 1'b0 || obs_start !== 2 || obs_data !== scramble(a, b, 5'b00100, 3'b111, 3'b111, 1'b1)) begin
            failures++;
            $display("[TB] FAIL rm_insensitive got ill=%b start=%0d data=%h exp 0/2/%h",
                     obs_ill, obs_start, obs_data, scramble(a, b, 5'b00100, 3'b111, 3'b111, 1'b1));
        end
        do_txn(5'b01011, 3'b111, 3'b100, a, b, 1'b0, 5'd10, 0, 5'd0, 0);
        checks++;
        if (obs_ill !== 1'b0 || obs_start !== 2 || !obs_latch_ok) begin
            failures++;
            $display("[TB] FAIL rm_dyn_rmm got ill=%b start=%0d latch=%0d exp 0/2/1", obs_ill, obs_start, obs_latch_ok);
        end
    endtask

    task automatic test_timeout;
        logic [31:0] a, b;
        model_hang = 1; model_flags = 5'b11111; model_fixed_en = 0;
        do_txn(5'b00011, 3'b000, 3'b000, $urandom, $urandom, 1'b0, 5'd21, 0, 5'd0, 0);
        checks++;
        if (obs_start !== TIMEOUT || obs_wait !== TIMEOUT + 1 || obs_to !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_abort got start=%0d wait=%0d to=%b exp %0d/%0d/1",
                     obs_start, obs_wait, obs_to, TIMEOUT, TIMEOUT + 1);
        end
        checks++;
        if (obs_data !== 32'h0 || obs_ff !== 5'b0 || obs_acc !== ref_acc || obs_after_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_resp got data=%h ff=%b acc=%b valid=%b exp 0/0/%b/0",
                     obs_data, obs_ff, obs_acc, obs_after_valid, ref_acc);
        end
        model_hang = 0; model_lat = 3; model_flags = 5'b00010;
        a = $urandom; b = $urandom;
        do_txn(5'b00001, 3'b001, 3'b000, a, b, 1'b0, 5'd22, 0, 5'd0, 0);
        ref_acc = ref_acc | 5'b00010;
        checks++;
        if (obs_to !== 1'b0 || obs_start !== 4 || obs_data !== scramble(a, b, 5'b00001, 3'b001, 3'b000, 1'b0) ||
            obs_acc !== ref_acc) begin
            failures++;
            $display("[TB] FAIL after_timeout got to=%b start=%0d data=%h acc=%b exp 0/4/%h/%b",
                     obs_to, obs_start, obs_data, obs_acc, scramble(a, b, 5'b00001, 3'b001, 3'b000, 1'b0), ref_acc);
        end
        // Done on the very last allowed cycle must beat the watchdog
        model_lat = TIMEOUT - 1; model_flags = 5'b00100;
        do_txn(5'b00000, 3'b000, 3'b000, a, b, 1'b0, 5'd23, 0, 5'd0, 0);
        ref_acc = ref_acc | 5'b00100;
        checks++;
        if (obs_to !== 1'b0 || obs_start !== TIMEOUT || obs_ff !== 5'b00100 || obs_acc !== ref_acc) begin
            failures++;
            $display("[TB] FAIL done_at_limit got to=%b start=%0d ff=%b acc=%b exp 0/%0d/00100/%b",
                     obs_to, obs_start, obs_ff, obs_acc, TIMEOUT, ref_acc);
        end
    endtask

    task automatic test_flush;
        int seen;
        model_hang = 0; model_fixed_en = 1; model_fixed = 32'h7F800000;
        for (int variant = 0; variant < 2; variant++) begin
            model_lat = (variant == 0) ? 19 : 2;
            model_flags = 5'b10101;
            @(negedge clk);
            bus.req_op = 5'b00011; bus.req_rm = 3'b000; bus.req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = 1'b0;
            repeat ((variant == 0) ? 4 : 2) @(negedge clk);
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
            checks++;
            if (bus.fpu_start !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
                bus.fflags_acc !== ref_acc) begin
                failures++;
                $display("[TB] FAIL flush_%0d got start=%b valid=%b ready=%b acc=%b exp 0/0/1/%b",
                         variant, bus.fpu_start, bus.rsp_valid, bus.req_ready, bus.fflags_acc, ref_acc);
            end
            seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (bus.rsp_valid !== 1'b0 || bus.fpu_start !== 1'b0) seen++;
            end
            checks++;
            if (seen !== 0) begin
                failures++;
                $display("[TB] FAIL flush_quiet_%0d got activity=%0d exp 0", variant, seen);
            end
        end
        model_lat = 0; model_flags = 5'b00000; model_fixed = 32'h40400000;
        do_txn(5'b00000, 3'b000, 3'b000, 32'h3F800000, 32'h40000000, 1'b0, 5'd5, 0, 5'd0, 0);
        checks++;
        if (obs_data !== 32'h40400000 || obs_start !== 1 || obs_acc !== ref_acc) begin
            failures++;
            $display("[TB] FAIL flush_then_fadd got data=%h start=%0d acc=%b exp 40400000/1/%b",
                     obs_data, obs_start, obs_acc, ref_acc);
        end
    endtask

    task automatic test_csr_on_capture;
        model_lat = 2; model_hang = 0; model_flags = 5'b00001;
        model_fixed_en = 1; model_fixed = 32'h12345678;
        do_txn(5'b00000, 3'b000, 3'b000, $urandom, $urandom, 1'b0, 5'd30, 1, 5'b10000, 10);
        ref_acc = 5'b10001;
        checks++;
        if (obs_acc !== 5'b10001 || obs_ff !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL csr_capture got acc=%b ff=%b exp 10001/00001", obs_acc, obs_ff);
        end
        checks++;
        if (!obs_stable || obs_data !== 32'h12345678 || obs_rd !== 5'd30) begin
            failures++;
            $display("[TB] FAIL hold_stable got stable=%0d data=%h rd=%0d exp 1/12345678/30",
                     obs_stable, obs_data, obs_rd);
        end
    endtask

    task automatic test_random;
        logic [4:0] op, rd, flags, wdata, e_ff, e_acc;
        logic [2:0] rm, frm;
        logic [31:0] a, b, e_data;
        logic rs2;
        bit hang, wr, ill;
        int lat, e_start;
        model_fixed_en = 0;
        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom_range(0, 28)); rm = 3'($urandom); frm = 3'($urandom);
            a = $urandom; b = $urandom; rs2 = 1'($urandom); rd = 5'($urandom);
            flags = 5'($urandom); wdata = 5'($urandom);
            hang = ($urandom_range(0, 9) == 0); wr = ($urandom_range(0, 3) == 0);
            lat = $urandom_range(0, 6);
            model_lat = lat; model_hang = hang; model_flags = flags;
            ill = is_illegal(op, rm, frm);
            if (ill) begin
                e_start = 0; e_data = '0; e_ff = '0; e_acc = ref_acc;
            end else if (hang) begin
                e_start = TIMEOUT; e_data = '0; e_ff = '0; e_acc = ref_acc;
            end else begin
                e_start = lat + 1; e_data = scramble(a, b, op, rm, frm, rs2); e_ff = flags;
                e_acc = (wr ? wdata : ref_acc) | flags;
            end
            do_txn(op, rm, frm, a, b, rs2, rd, wr, wdata, $urandom_range(0, 3));
            ref_acc = e_acc;
            checks++;
            if (obs_data !== e_data || obs_ff !== e_ff || obs_rd !== rd) begin
                failures++;
                $display("[TB] FAIL rand%0d_rsp got data=%h ff=%b rd=%0d exp %h/%b/%0d",
                         n, obs_data, obs_ff, obs_rd, e_data, e_ff, rd);
            end
            checks++;
            if (obs_ill !== 1'(ill) || obs_to !== 1'(hang && !ill) || obs_start !== e_start ||
                obs_wait !== e_start + (ill ? 1 : 1)) begin
                failures++;
                $display("[TB] FAIL rand%0d_ctrl got ill=%b to=%b start=%0d wait=%0d exp %b/%b/%0d/%0d",
                         n, obs_ill, obs_to, obs_start, obs_wait, ill, hang && !ill, e_start, e_start + 1);
            end
            checks++;
            if (obs_acc !== e_acc || !obs_stable || !obs_latch_ok || obs_after_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rand%0d_state got acc=%b stable=%0d latch=%0d valid=%b exp %b/1/1/0",
                         n, obs_acc, obs_stable, obs_latch_ok, obs_after_valid, e_acc);
            end
        end
    endtask

    task automatic test_async_reset;
        model_hang = 1;
        @(negedge clk);
        bus.req_op = 5'b00011; bus.req_rm = 3'b000; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.fpu_start !== 1'b0 || bus.req_ready !== 1'b1 || bus.fflags_acc !== 5'b0) begin
            failures++;
            $display("[TB] FAIL async_reset got start=%b ready=%b acc=%b exp 0/1/00000",
                     bus.fpu_start, bus.req_ready, bus.fflags_acc);
        end
        @(negedge clk);
        reset = 1'b0;
        model_hang = 0;
        ref_acc = '0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.fpu_start !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_reset got valid=%b start=%b exp 0/0", bus.rsp_valid, bus.fpu_start);
        end
    endtask

    initial begin
        test_reset;
        test_csr_write;
        test_single_cycle;
        test_multi_cycle;
        test_illegal;
        test_rm_boundaries;
        test_timeout;
        test_flush;
        test_csr_on_capture;
        test_random;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Core-side initiator for the FPU arithmetic unit. It accepts one FP instruction at a time from the execute stage over a valid/ready handshake and drives the FPU's start/op/rounding/operand inputs. Start is held high until the FPU asserts done, then the result and exception flags are captured and returned on a valid/ready response port. It also owns the accumulated fflags CSR state and guards against a hung multi-cycle operation with a watchdog.

Parameters:
TIMEOUT, 64, cycles fpu_start may stay high without fpu_done before the op is aborted.
CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  kill any in-flight op; synchronous
req_valid  input  1  request present
req_ready  output  1  high only in IDLE
req_op  input  5  FPU op code (FADD=00000 … class=11100)
req_rm  input  3  instruction rm field (111 = dynamic)
req_a, req_b  input  32  operands
req_rs2_lsb  input  1  signed/unsigned select for cvt ops
req_rd  input  5  destination tag, returned unchanged
csr_frm  input  3  dynamic rounding mode, sampled at accept
fpu_start  output  1  registered; held high through BUSY
fpu_op, fpu_rounding_mode, fpu_dyn_rm  output  5/3/3  latched req_op, req_rm, csr_frm
fpu_A, fpu_B  output  32  latched operands
fpu_rs2_lsb  output  1  latched
fpu_out  input  32  FPU result
fpu_done  input  1  FPU done (may be combinational on fpu_start)
fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx  input  1 each  FPU flags, valid while fpu_done=1
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts
rsp_data  output  32  captured result
rsp_rd  output  5  tag
rsp_fflags  output  5  {NV,DZ,OF,UF,NX} of this op
rsp_illegal  output  1  reserved rounding mode; FPU not started
rsp_timeout  output  1  watchdog abort
csr_fflags_we  input  1  CSR write strobe
csr_fflags_wdata  input  5  CSR write data
fflags_acc  output  5  accumulated fflags CSR value

Behaviour:
- Reset: state=IDLE; every output and latched field 0 (req_ready=1 in IDLE); fflags_acc=0; counter=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid, latch all req fields and csr_frm.
  - Rounding-sensitive ops are 00000, 00001, 00010, 00011, 01011, 11000 and 11010.
  - Effective rm = (req_rm==111 ? csr_frm : req_rm). If the op is rounding-sensitive and effective rm is 101, 110 or 111, go to RESP with rsp_illegal=1, rsp_data=0, rsp_fflags=0. fpu_start is never raised.
  - Otherwise go to BUSY, fpu_start=1 and counter=0.
- BUSY: fpu_start=1 and counter increments each cycle.
  - fpu_done=1: capture fpu_out and the five flags; fpu_start=0; go to RESP.
  - counter==TIMEOUT-1 with no done: rsp_timeout=1, rsp_data=0, rsp_fflags=0, fpu_start=0, go to RESP.
  - fpu_done wins over timeout when both occur in the same cycle.
- RESP: rsp_valid=1 with stable data. On rsp_ready, clear rsp_valid, rsp_illegal and rsp_timeout, then go to IDLE.
  - No new request is accepted in RESP, so fpu_start is low for at least one cycle between ops.
- Latency: accept on edge k → fpu_start high during cycle k+1. A single-cycle op captures on edge k+1, so rsp_valid is high from edge k+1. Multi-cycle ops add their done latency.
- Flush (any state): on the next edge, state=IDLE, fpu_start=0, rsp_valid=0, flags and data discarded, fflags_acc not updated. Flush has priority over done, timeout and rsp_ready.
- fflags_acc: on a capture edge it ORs in the captured flags.
  - If csr_fflags_we is high on the same edge, fflags_acc = csr_fflags_wdata | captured flags.
  - A write with no capture loads wdata.
  - Illegal and timeout responses contribute no flags.
- Async reset mid-BUSY: fpu_start drops immediately; the FPU is also reset by the same signal.

Test Plan:
- FADD A=0x3F800000, B=0x40000000, rm=000, FPU model done=start → rsp_data=0x40400000, rsp_fflags=00000, rsp_valid exactly 1 edge after fpu_start rises; fflags_acc=00000.
- FDIV A=0x3F800000, B=0x00000000, model done after 20 cycles → fpu_start high for 20 cycles, rsp_data=0x7F800000, rsp_fflags=01000, fflags_acc=01000.
- FMUL with req_rm=111, csr_frm=101 → rsp_illegal=1 the cycle after accept, fpu_start never 1, fflags_acc unchanged.
- Model never asserts done, TIMEOUT=64 → fpu_start high exactly 64 cycles, then rsp_timeout=1, rsp_data=0; next request is accepted normally.
- flush asserted in the 5th BUSY cycle of an FDIV → IDLE next edge, no rsp_valid, fflags_acc unchanged; a following FADD completes correctly.
- Capture with flags NX=00001 on the same edge as csr_fflags_we=1, wdata=10000 → fflags_acc=10001. Holding rsp_ready=0 for 10 cycles keeps rsp_data stable and req_ready=0.
